// File: rtl/rst_scalar_spec.sv
// Scalar register status table for the dispatch stage.
// Each architectural register records whether a functional unit still owes
// its result, and which FU tag will produce it. One level of branch speculation
// is supported through a per-entry shadow copy that a mispredict restores.
//
// Handshake: this block has none. Every input is sampled on each rising CLK
// edge. Lookups are combinational and read only the registered table, so a
// writeback is not bypassed to a lookup in the same cycle. x0 is never busy.
module rst_scalar_spec #(
    parameter int NREG  = 32,
    parameter int TAG_W = 2,
    parameter int NWB   = 2,
    parameter int RW    = $clog2(NREG),
    localparam int CW   = $clog2(NREG + 1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               di_en,
    input  logic [RW-1:0]      di_rd,
    input  logic [TAG_W-1:0]   di_tag,
    input  logic               di_spec,
    input  logic [RW-1:0]      rs1_sel,
    input  logic [RW-1:0]      rs2_sel,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic [TAG_W-1:0]   rs1_tag,
    output logic [TAG_W-1:0]   rs2_tag,
    output logic               rd_busy,
    input  logic [NWB-1:0]     wb_en,
    input  logic [NWB*RW-1:0]  wb_rd,
    input  logic [NWB*TAG_W-1:0] wb_tag,
    input  logic               br_resolved,
    input  logic               br_miss,
    output logic [CW-1:0]      busy_count
);

    // Live state of each entry
    logic [NREG-1:0]             busy_q, busy_d;
    logic [NREG-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [NREG-1:0]             spec_q, spec_d;
    // Shadow copy taken when an entry first becomes speculative
    logic [NREG-1:0]             shv_q, shv_d;
    logic [NREG-1:0]             shb_q, shb_d;
    logic [NREG-1:0][TAG_W-1:0]  sht_q, sht_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    // Next state per entry: branch outcome, then writebacks, then allocation
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        spec_d = spec_q;
        shv_d  = shv_q;
        shb_d  = shb_q;
        sht_d  = sht_q;
        cnt_d  = '0;
        // Entry 0 is skipped so x0 keeps its reset value of all zeros.
        for (int i = 1; i < NREG; i++) begin
            // A mispredict takes precedence when both branch signals are raised.
            if (br_miss) begin
                if (spec_q[i]) begin
                    busy_d[i] = shv_q[i] & shb_q[i];
                    tag_d[i]  = (shv_q[i] & shb_q[i]) ? sht_q[i] : '0;
                end
                spec_d[i] = 1'b0;
                shv_d[i]  = 1'b0;
            end else if (br_resolved) begin
                spec_d[i] = 1'b0;
                shv_d[i]  = 1'b0;
            end

            // A writeback whose tag does not match is a stale result and is dropped.
            // The shadow is checked independently, so a result that arrives while the
            // entry is speculatively reallocated still retires the older producer.
            for (int p = 0; p < NWB; p++) begin
                if (wb_en[p] && (wb_rd[p*RW +: RW] == RW'(i))) begin
                    if (busy_d[i] && (tag_d[i] == wb_tag[p*TAG_W +: TAG_W])) begin
                        busy_d[i] = 1'b0;
                        tag_d[i]  = '0;
                        spec_d[i] = 1'b0;
                    end
                    if (shv_d[i] && shb_d[i] && (sht_d[i] == wb_tag[p*TAG_W +: TAG_W])) begin
                        shb_d[i] = 1'b0;
                        sht_d[i] = '0;
                    end
                end
            end

            // Allocation is applied last and wins. A speculative allocation that
            // arrives together with a mispredict belongs to the squashed path.
            if (di_en && (di_rd == RW'(i)) && !(di_spec && br_miss)) begin
                if (di_spec && !spec_d[i]) begin
                    shv_d[i] = 1'b1;
                    shb_d[i] = busy_d[i];
                    sht_d[i] = tag_d[i];
                end
                busy_d[i] = 1'b1;
                tag_d[i]  = di_tag;
                spec_d[i] = di_spec;
            end
        end
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + CW'(busy_d[i]);
        end
    end

    // Table and busy-count registers, cleared asynchronously
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            tag_q  <= '0;
            spec_q <= '0;
            shv_q  <= '0;
            shb_q  <= '0;
            sht_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            spec_q <= spec_d;
            shv_q  <= shv_d;
            shb_q  <= shb_d;
            sht_q  <= sht_d;
            cnt_q  <= cnt_d;
        end
    end

    // Combinational lookups from registered state. Index 0 always reads as idle,
    // and the tag reads as 0 whenever the entry is not busy.
    always_comb begin
        rs1_busy = (rs1_sel != '0) && busy_q[rs1_sel];
        rs2_busy = (rs2_sel != '0) && busy_q[rs2_sel];
        rd_busy  = (di_rd != '0) && busy_q[di_rd];
        rs1_tag  = rs1_busy ? tag_q[rs1_sel] : '0;
        rs2_tag  = rs2_busy ? tag_q[rs2_sel] : '0;
    end

    assign busy_count = cnt_q;

endmodule

// File: tb/tb_rst_scalar_spec.sv
// Bench for rst_scalar_spec: directed scenarios plus a randomized run
// checked against an undo-log model of the register status table.
module tb_rst_scalar_spec;

    localparam int NREG  = 32;
    localparam int TAG_W = 2;
    localparam int NWB   = 2;
    localparam int RW    = 5;
    localparam int CW    = 6;

    logic                  CLK;
    logic                  nRST;
    logic                  di_en;
    logic [RW-1:0]         di_rd;
    logic [TAG_W-1:0]      di_tag;
    logic                  di_spec;
    logic [RW-1:0]         rs1_sel, rs2_sel;
    logic                  rs1_busy, rs2_busy;
    logic [TAG_W-1:0]      rs1_tag, rs2_tag;
    logic                  rd_busy;
    logic [NWB-1:0]        wb_en;
    logic [NWB*RW-1:0]     wb_rd;
    logic [NWB*TAG_W-1:0]  wb_tag;
    logic                  br_resolved, br_miss;
    logic [CW-1:0]         busy_count;

    rst_scalar_spec #(.NREG(NREG), .TAG_W(TAG_W), .NWB(NWB)) dut (
        .CLK(CLK), .nRST(nRST),
        .di_en(di_en), .di_rd(di_rd), .di_tag(di_tag), .di_spec(di_spec),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd_busy(rd_busy),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .br_resolved(br_resolved), .br_miss(br_miss),
        .busy_count(busy_count)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // The table is a simple map reg -> (busy, tag, speculative). Speculation is
    // kept as an undo log: the first speculative write to a register records
    // what it held before, and a mispredict replays those records.
    typedef struct {
        int r;
        bit b;
        int t;
    } undo_t;

    bit    m_busy[NREG];
    int    m_tag[NREG];
    bit    m_spec[NREG];
    undo_t ulog[$];

    // Scoreboard of expected busy_count values, one per clock edge.
    logic [CW-1:0] exp_q[$];

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = 0;
            m_spec[r] = 1'b0;
        end
        ulog.delete();
        exp_q.delete();
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step(output int cnt);
        int r;
        int t;
        if (br_miss) begin
            foreach (ulog[k]) begin
                if (m_spec[ulog[k].r]) begin
                    m_busy[ulog[k].r] = ulog[k].b;
                    m_tag[ulog[k].r]  = ulog[k].b ? ulog[k].t : 0;
                end
            end
            for (int i = 0; i < NREG; i++) m_spec[i] = 1'b0;
            ulog.delete();
        end else if (br_resolved) begin
            for (int i = 0; i < NREG; i++) m_spec[i] = 1'b0;
            ulog.delete();
        end
        for (int p = 0; p < NWB; p++) begin
            r = int'(wb_rd[p*RW +: RW]);
            t = int'(wb_tag[p*TAG_W +: TAG_W]);
            if (wb_en[p] && r != 0) begin
                if (m_busy[r] && m_tag[r] == t) begin
                    m_busy[r] = 1'b0;
                    m_tag[r]  = 0;
                    m_spec[r] = 1'b0;
                end
                foreach (ulog[k]) begin
                    if (ulog[k].r == r && ulog[k].b && ulog[k].t == t) ulog[k].b = 1'b0;
                end
            end
        end
        r = int'(di_rd);
        if (di_en && r != 0 && !(di_spec && br_miss)) begin
            if (di_spec && !m_spec[r]) begin
                for (int k = ulog.size() - 1; k >= 0; k--) begin
                    if (ulog[k].r == r) ulog.delete(k);
                end
                ulog.push_back('{r: r, b: m_busy[r], t: m_tag[r]});
            end
            m_busy[r] = 1'b1;
            m_tag[r]  = int'(di_tag);
            m_spec[r] = di_spec;
        end
        cnt = 0;
        for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        di_en = 1'b0; di_rd = '0; di_tag = '0; di_spec = 1'b0;
        wb_en = '0; wb_rd = '0; wb_tag = '0;
        br_resolved = 1'b0; br_miss = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_clear();
    endtask

    task automatic tick();
        int c;
        model_step(c);
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic alloc(input int rd, input int tag, input bit spec);
        di_en = 1'b1; di_rd = RW'(rd); di_tag = TAG_W'(tag); di_spec = spec;
    endtask

    task automatic wb(input int p, input int rd, input int tag);
        wb_en[p] = 1'b1;
        wb_rd[p*RW +: RW] = RW'(rd);
        wb_tag[p*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic look(input int sel, output logic b, output logic [TAG_W-1:0] t);
        rs1_sel = RW'(sel);
        rs2_sel = RW'(sel);
        #1;
        b = rs1_busy;
        t = rs1_tag;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        for (int r = 0; r < NREG; r++) begin
            look(r, b, t);
            n_cmp++;
            if (b !== 1'b0 || t !== '0 || rs2_busy !== 1'b0 || rs2_tag !== '0) begin
                n_err++;
                $display("FAIL reset_lookup x%0d: busy=%0b tag=%0d, want busy=0 tag=0", r, b, t);
            end
        end
        n_cmp++;
        if (busy_count !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d, want 0", busy_count);
        end
    endtask

    task automatic test_basic();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(5, 2, 0); tick();
        look(5, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd2 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL basic_alloc: busy=%0b tag=%0d count=%0d, want 1/2/1", b, t, busy_count);
        end
        wb(1, 5, 2); tick();
        look(5, b, t);
        n_cmp++;
        if (b !== 1'b0 || t !== 2'd0 || busy_count !== 6'd0) begin
            n_err++;
            $display("FAIL basic_wb: busy=%0b tag=%0d count=%0d, want 0/0/0", b, t, busy_count);
        end
    endtask

    task automatic test_stale_wb();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(7, 1, 0); tick();
        alloc(7, 3, 0); tick();
        wb(0, 7, 1); tick();
        look(7, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd3 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL stale_wb: busy=%0b tag=%0d count=%0d, want 1/3/1", b, t, busy_count);
        end
    endtask

    task automatic test_squash();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(9, 1, 0); tick();
        alloc(9, 2, 1); tick();
        alloc(10, 3, 1); tick();
        look(9, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd2 || busy_count !== 6'd2) begin
            n_err++;
            $display("FAIL squash_pre: busy=%0b tag=%0d count=%0d, want 1/2/2", b, t, busy_count);
        end
        br_miss = 1'b1; tick();
        look(9, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd1) begin
            n_err++;
            $display("FAIL squash_x9: busy=%0b tag=%0d, want busy=1 tag=1", b, t);
        end
        look(10, b, t);
        n_cmp++;
        if (b !== 1'b0 || t !== 2'd0 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL squash_x10: busy=%0b tag=%0d count=%0d, want 0/0/1", b, t, busy_count);
        end
    endtask

    task automatic test_shadow_wb();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(9, 1, 0); tick();
        alloc(9, 2, 1); tick();
        alloc(10, 3, 1); tick();
        wb(0, 9, 1); tick();
        look(9, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd2) begin
            n_err++;
            $display("FAIL shadow_wb_live: busy=%0b tag=%0d, want busy=1 tag=2", b, t);
        end
        br_miss = 1'b1; tick();
        look(9, b, t);
        n_cmp++;
        if (b !== 1'b0 || t !== 2'd0 || busy_count !== 6'd0) begin
            n_err++;
            $display("FAIL shadow_wb_restore: busy=%0b tag=%0d count=%0d, want 0/0/0", b, t, busy_count);
        end
    endtask

    task automatic test_commit_spec();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(4, 1, 1); tick();
        br_resolved = 1'b1;
        alloc(6, 2, 1); tick();
        look(6, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd2 || busy_count !== 6'd2) begin
            n_err++;
            $display("FAIL commit_alloc: busy=%0b tag=%0d count=%0d, want 1/2/2", b, t, busy_count);
        end
        br_miss = 1'b1; tick();
        look(4, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd1) begin
            n_err++;
            $display("FAIL commit_x4: busy=%0b tag=%0d, want busy=1 tag=1", b, t);
        end
        look(6, b, t);
        n_cmp++;
        if (b !== 1'b0 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL commit_x6: busy=%0b count=%0d, want busy=0 count=1", b, busy_count);
        end
    endtask

    task automatic test_same_cycle();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(3, 0, 0); tick();
        wb(0, 3, 0);
        alloc(3, 1, 0); tick();
        look(3, b, t);
        n_cmp++;
        if (b !== 1'b1 || t !== 2'd1 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL wb_alloc_same: busy=%0b tag=%0d count=%0d, want 1/1/1", b, t, busy_count);
        end
        alloc(0, 3, 0);
        #1;
        n_cmp++;
        if (rd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL x0_rd_busy: got %0b, want 0", rd_busy);
        end
        tick();
        look(0, b, t);
        n_cmp++;
        if (b !== 1'b0 || t !== 2'd0 || busy_count !== 6'd1) begin
            n_err++;
            $display("FAIL x0_alloc: busy=%0b tag=%0d count=%0d, want 0/0/1", b, t, busy_count);
        end
    endtask

    task automatic test_reset_mid_spec();
        logic b; logic [TAG_W-1:0] t;
        do_reset();
        alloc(11, 1, 0); tick();
        alloc(11, 2, 1); tick();
        alloc(12, 3, 1); tick();
        // Pulse reset between clock edges so only the asynchronous path can clear.
        @(negedge CLK);
        #1 nRST = 1'b0;
        #2 nRST = 1'b1;
        model_clear();
        for (int r = 0; r < NREG; r++) begin
            look(r, b, t);
            n_cmp++;
            if (b !== 1'b0 || t !== '0) begin
                n_err++;
                $display("FAIL async_reset_lookup x%0d: busy=%0b tag=%0d, want 0/0", r, b, t);
            end
        end
        n_cmp++;
        if (busy_count !== '0) begin
            n_err++;
            $display("FAIL async_reset_count: got %0d, want 0", busy_count);
        end
        // A mispredict right after must not resurrect anything from before reset.
        br_miss = 1'b1; tick();
        look(11, b, t);
        n_cmp++;
        if (b !== 1'b0 || busy_count !== '0) begin
            n_err++;
            $display("FAIL async_reset_miss: busy=%0b count=%0d, want 0/0", b, busy_count);
        end
    endtask

    task automatic test_random();
        int c;
        int s1, s2, br;
        logic [CW-1:0] exp_cnt;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            di_en   = ($urandom_range(0, 3) != 0);
            di_rd   = RW'($urandom_range(0, 7));
            di_tag  = TAG_W'($urandom_range(0, 3));
            di_spec = $urandom_range(0, 1) == 1;
            for (int p = 0; p < NWB; p++) begin
                wb_en[p] = $urandom_range(0, 1) == 1;
                wb_rd[p*RW +: RW] = RW'($urandom_range(0, 7));
                wb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
            end
            br = $urandom_range(0, 9);
            br_miss     = (br == 0);
            br_resolved = (br == 1);
            s1 = $urandom_range(0, 7);
            s2 = $urandom_range(0, NREG - 1);
            rs1_sel = RW'(s1);
            rs2_sel = RW'(s2);
            #1;
            n_cmp++;
            if (rs1_busy !== m_busy[s1] || int'(rs1_tag) != (m_busy[s1] ? m_tag[s1] : 0)) begin
                n_err++;
                $display("FAIL rand_rs1 cyc %0d x%0d: busy=%0b tag=%0d, want busy=%0b tag=%0d",
                         cyc, s1, rs1_busy, rs1_tag, m_busy[s1], m_tag[s1]);
            end
            n_cmp++;
            if (rs2_busy !== m_busy[s2] || int'(rs2_tag) != (m_busy[s2] ? m_tag[s2] : 0)) begin
                n_err++;
                $display("FAIL rand_rs2 cyc %0d x%0d: busy=%0b tag=%0d, want busy=%0b tag=%0d",
                         cyc, s2, rs2_busy, rs2_tag, m_busy[s2], m_tag[s2]);
            end
            n_cmp++;
            if (rd_busy !== m_busy[int'(di_rd)]) begin
                n_err++;
                $display("FAIL rand_rd_busy cyc %0d x%0d: got %0b, want %0b",
                         cyc, di_rd, rd_busy, m_busy[int'(di_rd)]);
            end
            model_step(c);
            exp_q.push_back(CW'(c));
            @(posedge CLK);
            #1;
            idle_inputs();
            exp_cnt = exp_q.pop_front();
            n_cmp++;
            if (busy_count !== exp_cnt) begin
                n_err++;
                $display("FAIL rand_count cyc %0d: got %0d, want %0d", cyc, busy_count, exp_cnt);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        nRST = 1'b0;
        rs1_sel = '0;
        rs2_sel = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stale_wb();
        test_squash();
        test_shadow_wb();
        test_commit_spec();
        test_same_cycle();
        test_reset_mid_spec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
